toll_event_uart_tx: RTL

Transmit-side UART reporter for the Intelligent Tolling System. Watches the `toll_controller` outputs (`gate_open`, `tailgate_alert`, `ev_discount`) and detects their rising edges. Each detection becomes one event byte, queued in a small FIFO and serialized as 8N1 UART frames on `tx` to the roadside host. This is the outbound counterpart to the inbound `uart_rx_sim` to `uart_data` path. It is instantiated beside `toll_ctrl` in the system testbench and in the top level.

---
 rtl/toll_event_uart_tx_pkg.sv | 25 ++
 rtl/toll_event_uart_tx_core.sv | 102 ++++++++++
 rtl/toll_event_uart_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/toll_event_uart_tx_pkg.sv
// Shared constants for the toll event UART reporter: event byte layout and
// transmitter FSM state encodings.
package toll_pkg;

    localparam logic [3:0] EVT_HDR = 4'hA;

    localparam int EVT_G = 0;
    localparam int EVT_E = 1;
    localparam int EVT_T = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic logic [7:0] evt_byte(input logic g, input logic e, input logic t);
        logic [7:0] b;
        b        = {EVT_HDR, 4'h0};
        b[EVT_G] = g;
        b[EVT_E] = e;
        b[EVT_T] = t;
        return b;
    endfunction

endpackage

// File: rtl/toll_event_uart_tx_core.sv
// 8N1 serializer: takes one byte per valid&ready handshake and shifts it out
// LSB first, chaining straight into the next start bit when data is waiting.
module uart_tx_core
    import toll_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       active
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx_r;
    logic          bit_end;

    assign bit_end = (timer == T_LAST);
    // Ready on the last stop cycle lets the next frame start with no idle gap.
    assign ready   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
    assign active  = (state != ST_IDLE);
    assign tx      = tx_r;

    // Frame sequencer, bit timer and shift register; tx is registered with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (valid) begin
                        shreg <= data;
                        state <= ST_START;
                        tx_r  <= 1'b0;
                    end else begin
                        tx_r  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= 3'd0;
                        state   <= ST_DATA;
                        tx_r    <= shreg[0];
                    end else begin
                        timer   <= timer + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_r  <= 1'b1;
                        end else begin
                            tx_r  <= shreg[1];
                        end
                    end else begin
                        timer   <= timer + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (valid) begin
                            shreg <= data;
                            state <= ST_START;
                            tx_r  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx_r  <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                    tx_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/toll_event_uart_tx.sv
// Toll controller event reporter: rising-edge detect on three status levels,
// coalesce into event bytes, queue them and send them out over UART.
module toll_event_uart_tx
    import toll_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        gate_open,
    input  logic                        tailgate_alert,
    input  logic                        ev_discount,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [2:0]    prev;
    logic          g_edge;
    logic          e_edge;
    logic          t_edge;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          ready;
    logic          active;
    logic [7:0]    evt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow_r;

    assign g_edge   = gate_open      & ~prev[0];
    assign e_edge   = ev_discount    & ~prev[1];
    assign t_edge   = tailgate_alert & ~prev[2];
    assign push_req = g_edge | e_edge | t_edge;
    assign evt      = evt_byte(g_edge, e_edge, t_edge);

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign pop      = ready && (count != '0);
    // A full queue still accepts a byte when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);

    assign busy       = active || (count != '0);
    assign overflow   = overflow_r;
    assign fifo_count = count;

    // Previous-value registers for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 3'b000;
        end else begin
            prev <= {tailgate_alert, ev_discount, gate_open};
        end
    end

    // Event FIFO storage, pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= evt;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_req && !push_ok) begin
                overflow_r <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .data  (mem[rd_ptr]),
        .valid (count != '0),
        .ready (ready),
        .tx    (tx),
        .active(active)
    );

endmodule
